// File: rtl/i2s_tx_sched_if.sv
// i2s_tx_sched_if: valid/ready stereo sample stream into the I2S scheduler
//   master: drives s_valid, s_left, s_right; samples s_ready
//   slave:  samples s_valid, s_left, s_right; drives s_ready
interface i2s_tx_sched_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_left;
  logic [15:0] s_right;
  modport master(output s_valid, s_left, s_right, input s_ready);
  modport slave(input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_sched.sv
// i2s_tx_sched: buffers stereo samples and feeds one pair per I2S frame to the transmitter
//   sclk, rst                   bit clock, sync active-high reset
//   enable, cfg_load/prescaler  stream control and prescaler load; cfg_err flags a rejected load
//   s (slave)                   upstream sample stream
//   lrclk                       slot indicator from the transmitter
//   tx_rst, prescaler,
//   left_chan, right_chan       transmitter controls and next-frame samples
//   fifo_level, running,
//   underrun, underrun_cnt      status
module i2s_tx_sched #(
  parameter int DEPTH            = 8,
  parameter int PRIME_LEVEL      = 2,
  parameter int HOLD_ON_UNDERRUN = 0
) (
  input  logic                     sclk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     cfg_load,
  input  logic [15:0]              cfg_prescaler,
  output logic                     cfg_err,
  i2s_tx_sched_if.slave            s,
  input  logic                     lrclk,
  output logic                     tx_rst,
  output logic [15:0]              prescaler,
  output logic [15:0]              left_chan,
  output logic [15:0]              right_chan,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     running,
  output logic                     underrun,
  output logic [15:0]              underrun_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
  state_t        state_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic [31:0]   mem_q [DEPTH];
  logic [15:0]   prescaler_q, left_q, right_q, ucnt_q;
  logic          lrclk_q, cfg_err_q, underrun_q;
  logic          fb, empty, push, pop, prime_go, streaming, cfg_ok;
  // right->left slot change: the transmitter has just latched left/right_chan
  assign fb        = lrclk_q & ~lrclk;
  assign empty     = level_q == '0;
  assign s.s_ready = level_q != LW'(DEPTH);
  assign push      = s.s_valid & s.s_ready;
  assign streaming = state_q == RUN || state_q == DRAIN;
  assign prime_go  = state_q == PRIME && enable && level_q >= LW'(PRIME_LEVEL);
  assign pop       = prime_go || (streaming && fb && !empty);
  assign cfg_ok    = cfg_prescaler >= 16'd1 && cfg_prescaler <= 16'd16;
  assign cfg_err      = cfg_err_q;
  assign tx_rst       = !streaming;
  assign running      = streaming;
  assign prescaler    = prescaler_q;
  assign left_chan    = left_q;
  assign right_chan   = right_q;
  assign fifo_level   = level_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;
  always_ff @(posedge sclk)
    if (push) mem_q[wr_q] <= {s.s_left, s.s_right};
  always_ff @(posedge sclk)
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      prescaler_q <= 16'd16;
      left_q      <= '0;
      right_q     <= '0;
      ucnt_q      <= '0;
      lrclk_q     <= 1'b1;
      cfg_err_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      lrclk_q    <= lrclk;
      wr_q       <= wr_q + AW'(push);
      rd_q       <= rd_q + AW'(pop);
      level_q    <= level_q + LW'(push) - LW'(pop);
      cfg_err_q  <= cfg_load && !(state_q == IDLE && cfg_ok);
      underrun_q <= state_q == RUN && fb && empty;
      if (cfg_load && state_q == IDLE && cfg_ok) prescaler_q <= cfg_prescaler;
      if (state_q == RUN && fb && empty && ucnt_q != '1) ucnt_q <= ucnt_q + 16'd1;
      // on an empty boundary RUN may hold the last pair; DRAIN always clears
      if (pop) {left_q, right_q} <= mem_q[rd_q];
      else if (fb && empty && (state_q == DRAIN || (state_q == RUN && HOLD_ON_UNDERRUN == 0)))
        {left_q, right_q} <= '0;
      case (state_q)
        IDLE:    state_q <= enable ? PRIME : IDLE;
        PRIME:   state_q <= !enable ? IDLE : prime_go ? RUN : PRIME;
        RUN:     state_q <= enable ? RUN : DRAIN;
        default: state_q <= (fb && empty) ? IDLE : enable ? RUN : DRAIN;
      endcase
    end
endmodule
